sincronizador: RTL and testbench

SINCRONIZADOR -- requirements
Module: sincronizador

---
 rtl/sincronizador.sv | 104 ++++++++++
 tb/tb_sincronizador.sv | 80 ++++++++
 2 files changed

// File: rtl/sincronizador.sv
// sincronizador: 1000BASE-X receive code-group synchronization FSM, one code group per clock.
module sincronizador (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  rx_cg,
  output logic [10:0] SUDI,
  output logic        sync_status
);
  typedef enum logic [3:0] {
    LOSS_OF_SYNC, COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3,
    ACQUIRE_SYNC_1, ACQUIRE_SYNC_2,
    SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3,
    SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A
  } state_t;
  state_t      state_q, state_d;
  logic [1:0]  good_cgs_q, good_cgs_d;
  logic        rx_even_q, rx_even_d;
  logic [10:0] sudi_q, sudi_d;
  logic        sync_status_q, sync_status_d;
  logic        valid6, valid4, comma, k_code, invalid, data, cgbad, force_even;
  always_comb begin
    valid6 = rx_cg[9:4] inside {
      6'b100111, 6'b011000, 6'b011101, 6'b100010, 6'b101101, 6'b010010, 6'b110001,
      6'b110101, 6'b001010, 6'b101001, 6'b011001, 6'b111000, 6'b000111, 6'b111001,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100,
      6'b010111, 6'b101000, 6'b011011, 6'b100100, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b111010, 6'b000101, 6'b110011, 6'b001100,
      6'b100110, 6'b010110, 6'b110110, 6'b001001, 6'b001110, 6'b101110, 6'b010001,
      6'b011110, 6'b100001, 6'b101011, 6'b010100, 6'b001111, 6'b110000};
    valid4 = rx_cg[3:0] != 4'b0000 && rx_cg[3:0] != 4'b1111;
    comma = rx_cg[9:3] == 7'b0011111 || rx_cg[9:3] == 7'b1100000;
    // K23/K27/K29/K30 reuse data 6b codes; only the A7-style 4b tail marks them as K
    k_code = rx_cg[9:4] inside {6'b001111, 6'b110000} ||
             (rx_cg[9:4] inside {6'b111010, 6'b000101, 6'b110110, 6'b001001,
                                 6'b101110, 6'b010001, 6'b011110, 6'b100001} &&
              rx_cg[3:0] inside {4'b0111, 4'b1000});
    invalid = !(valid6 && valid4);
    data = !invalid && !k_code;
    cgbad = invalid || (comma && rx_even_q);
  end
  always_comb begin
    state_d = state_q;
    good_cgs_d = good_cgs_q;
    force_even = 1'b0;
    unique case (state_q)
      LOSS_OF_SYNC: if (comma) begin
        state_d = COMMA_DETECT_1;
        force_even = 1'b1;
      end
      COMMA_DETECT_1: state_d = data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
      COMMA_DETECT_2: state_d = data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
      COMMA_DETECT_3: state_d = data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1, ACQUIRE_SYNC_2: if (cgbad) state_d = LOSS_OF_SYNC;
      else if (comma) begin
        state_d = state_q == ACQUIRE_SYNC_1 ? COMMA_DETECT_2 : COMMA_DETECT_3;
        force_even = 1'b1;
      end
      SYNC_ACQUIRED_1: if (cgbad) state_d = SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_2: begin
        good_cgs_d = cgbad ? 2'd0 : 2'd1;
        state_d = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
      end
      SYNC_ACQUIRED_3: begin
        good_cgs_d = cgbad ? 2'd0 : 2'd1;
        state_d = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
      end
      SYNC_ACQUIRED_4: begin
        good_cgs_d = cgbad ? 2'd0 : 2'd1;
        state_d = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
      end
      SYNC_ACQUIRED_2A: if (cgbad) state_d = SYNC_ACQUIRED_3;
      else if (good_cgs_q == 2'd3) state_d = SYNC_ACQUIRED_1;
      else good_cgs_d = good_cgs_q + 2'd1;
      SYNC_ACQUIRED_3A: if (cgbad) state_d = SYNC_ACQUIRED_4;
      else if (good_cgs_q == 2'd3) state_d = SYNC_ACQUIRED_2;
      else good_cgs_d = good_cgs_q + 2'd1;
      SYNC_ACQUIRED_4A: if (cgbad) state_d = LOSS_OF_SYNC;
      else if (good_cgs_q == 2'd3) state_d = SYNC_ACQUIRED_3;
      else good_cgs_d = good_cgs_q + 2'd1;
      default: state_d = LOSS_OF_SYNC;
    endcase
    rx_even_d = force_even || !rx_even_q;
    sudi_d = {rx_even_d, rx_cg};
    sync_status_d = state_d inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
      SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOSS_OF_SYNC;
      good_cgs_q <= 2'd0;
      rx_even_q <= 1'b0;
      sudi_q <= 11'h000;
      sync_status_q <= 1'b0;
    end else begin
      state_q <= state_d;
      good_cgs_q <= good_cgs_d;
      rx_even_q <= rx_even_d;
      sudi_q <= sudi_d;
      sync_status_q <= sync_status_d;
    end
  end
  assign SUDI = sudi_q;
  assign sync_status = sync_status_q;
endmodule

// File: tb/tb_sincronizador.sv
// tb_sincronizador: directed code-group vectors with queued expected SUDI/sync_status, checked by a monitor.
module tb_sincronizador;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  rx_cg = 10'h000;
  logic [10:0] SUDI;
  logic        sync_status;
  int          n_checks = 0;
  int          n_fail = 0;
  int          row = 0;
  logic [11:0] exp_q[$];
  localparam logic [9:0] K = 10'b0011111010;
  localparam logic [9:0] KP = 10'b1100000101;
  localparam logic [9:0] D = 10'b0110110101;
  localparam logic [9:0] Z = 10'h000;
  localparam logic [9:0] K23 = 10'b1110101000;
  localparam logic [9:0] BAD4 = 10'b0110111111;
  sincronizador dut (
    .clk(clk), .reset(reset), .rx_cg(rx_cg), .SUDI(SUDI), .sync_status(sync_status)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [9:0] cg, input logic s, input logic e);
    @(negedge clk);
    reset = r;
    rx_cg = cg;
    exp_q.push_back({s, r ? 11'h000 : {e, cg}});
  endtask
  initial begin
    logic [11:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        row++;
        n_checks += 2;
        if (sync_status !== exp[11]) begin
          n_fail++;
          $display("FAIL sync_status row %0d: got %b expected %b", row, sync_status, exp[11]);
        end
        if (SUDI !== exp[10:0]) begin
          n_fail++;
          $display("FAIL SUDI row %0d: got %h expected %h", row, SUDI, exp[10:0]);
        end
      end
    end
  end
  initial begin
    step(1, Z, 0, 0); step(1, Z, 0, 0);
    step(0, K, 0, 1); step(0, D, 0, 0); step(0, K, 0, 1);
    step(0, D, 0, 0); step(0, K, 0, 1); step(0, D, 1, 0);
    step(0, K, 1, 1); step(0, D, 1, 0);
    step(0, Z, 1, 1); step(0, D, 1, 0); step(0, K, 1, 1); step(0, D, 1, 0); step(0, K, 1, 1);
    step(0, Z, 1, 0); step(0, Z, 1, 1); step(0, Z, 1, 0); step(0, Z, 0, 1);
    step(0, K, 0, 1); step(0, D, 0, 0); step(0, K, 0, 1);
    step(0, D, 0, 0); step(0, K, 0, 1); step(0, D, 1, 0);
    step(1, K, 0, 0);
    step(0, K, 0, 1); step(0, D, 0, 0); step(0, K, 0, 1);
    step(0, D, 0, 0); step(0, K, 0, 1); step(0, D, 1, 0);
    step(1, Z, 0, 0);
    step(0, K, 0, 1); step(0, D, 0, 0); step(0, D, 0, 1); step(0, K, 0, 0); step(0, D, 0, 1);
    step(0, K, 0, 1); step(0, D, 0, 0); step(0, K, 0, 1);
    step(0, D, 0, 0); step(0, K, 0, 1); step(0, D, 1, 0);
    step(0, K, 1, 1); step(0, D, 1, 0);
    step(1, Z, 0, 0);
    step(0, K, 0, 1); step(0, K, 0, 0); step(0, K, 0, 1); step(0, K23, 0, 0); step(0, D, 0, 1);
    step(0, K, 0, 1); step(0, D, 0, 0); step(0, BAD4, 0, 1);
    step(0, K, 0, 1); step(0, D, 0, 0); step(0, K, 0, 1);
    step(0, D, 0, 0); step(0, K, 0, 1); step(0, D, 1, 0);
    step(0, KP, 1, 1); step(0, D, 1, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
